// File: rtl/cache_nway_wb.sv
// cache_nway_wb -- N-way set-associative, write-back, write-allocate cache
// with a tree pseudo-LRU replacement policy.
//
// Sits between a CPU word port (32-bit data, byte enables, held request,
// one-cycle mem_resp pulse) and a line-wide physical memory port (one full
// line per pmem_read / pmem_write transfer, completed by pmem_resp).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   mem_address         CPU byte address (bits [1:0] ignored)
//   mem_read/mem_write  CPU request, held until mem_resp (write wins if both)
//   mem_byte_enable     byte lanes for writes
//   mem_wdata           CPU write data
//   mem_rdata           read data, valid while mem_resp = 1
//   mem_resp            one-cycle completion pulse
//   pmem_address        line-aligned memory address
//   pmem_read           line fill request
//   pmem_write          victim write-back request
//   pmem_wdata          victim line
//   pmem_rdata          fill line
//   pmem_resp           memory completion
//   hit_count           (CACHE_PERF_COUNTERS_EN only) saturating hit counter
//   miss_count          (CACHE_PERF_COUNTERS_EN only) saturating miss counter
//
// Optional feature macro: CACHE_PERF_COUNTERS_EN adds the two performance
// counter outputs; without it the ports and logic are absent.
module cache_nway_wb #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * (2 ** s_offset),
  parameter int num_sets = 2 ** s_index
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int s_way  = (num_ways > 1) ? $clog2(num_ways) : 1;
  localparam int s_word = s_offset - 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;

  // Captured request (data registers, not reset)
  logic [31:2]        req_addr_p0;
  logic               req_write_p0;
  logic [3:0]         req_be_p0;
  logic [31:0]        req_wdata_p0;
  logic [s_way-1:0]   victim_p0;

  // Flop-based arrays; plru node k lives at bit k (heap order, root = 1)
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [num_ways-1:1] plru_q  [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_line-1:0]   line_q  [num_sets][num_ways];

  logic [s_index-1:0]  idx;
  logic [s_tag-1:0]    req_tag;
  logic [s_word-1:0]   word_sel;

  assign idx      = req_addr_p0[s_offset +: s_index];
  assign req_tag  = req_addr_p0[31 -: s_tag];
  assign word_sel = req_addr_p0[s_offset-1:2];

  logic                hit;
  logic [s_way-1:0]    hit_way;
  logic                has_invalid;
  logic [s_way-1:0]    inv_way;
  logic [s_way-1:0]    plru_way;
  logic [s_way-1:0]    victim;
  logic                victim_dirty;
  logic [s_line-1:0]   hit_line;
  logic [31:0]         hit_word;
  logic [31:0]         merged_word;
  logic [s_line-1:0]   merged_line;
  logic [2*num_ways-1:0] tree;
  logic [num_ways-1:0] plru_upd;
  logic [num_ways-1:1] plru_next;
  logic [s_way:0]      node_v;
  logic [s_way-1:0]    node_u;
  logic [s_way-1:0]    way_sh;
  logic                fill_en;
  logic                hit_en;
  logic                unused_bits;

  assign unused_bits = ^{mem_address[1:0], plru_upd[0]};

  // Tag compare across all ways of the selected set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = s_way'(w);
      end
    end
  end

  // Lowest-index invalid way: scan downward so the lowest match wins
  always_comb begin
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = s_way'(w);
      end
    end
  end

  // Tree PLRU: walk from the root to find the victim, and compute the
  // updated node bits that point every node on hit_way's path away from it.
  always_comb begin
    tree   = {{num_ways{1'b0}}, plru_q[idx], 1'b0};
    node_v = (s_way+1)'(1);
    for (int l = 0; l < s_way; l++) begin
      node_v = (node_v << 1) | (s_way+1)'(tree[node_v]);
    end
    plru_way = node_v[s_way-1:0];

    plru_upd = {plru_q[idx], 1'b0};
    node_u   = s_way'(1);
    way_sh   = hit_way;
    for (int l = 0; l < s_way; l++) begin
      plru_upd[node_u] = ~way_sh[s_way-1];
      node_u           = (node_u << 1) | s_way'(way_sh[s_way-1]);
      way_sh           = way_sh << 1;
    end
    plru_next = plru_upd[num_ways-1:1];
  end

  assign victim       = has_invalid ? inv_way : plru_way;
  assign victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];

  // Word select and byte-lane merge for the hit way
  always_comb begin
    hit_line    = line_q[idx][hit_way];
    hit_word    = hit_line[{word_sel, 5'b0} +: 32];
    merged_word = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (req_be_p0[b]) merged_word[b*8 +: 8] = req_wdata_p0[b*8 +: 8];
    end
    merged_line = hit_line;
    merged_line[{word_sel, 5'b0} +: 32] = merged_word;
  end

  assign pmem_wdata = line_q[idx][victim_p0];
  assign fill_en    = (state == ALLOCATE) && pmem_resp;
  assign hit_en     = (state == CHECK) && hit;

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle carrying mem_resp still sees the old held request.
          if (!mem_resp && (mem_read || mem_write)) begin
            req_addr_p0  <= mem_address[31:2];
            req_write_p0 <= mem_write;
            req_be_p0    <= mem_byte_enable;
            req_wdata_p0 <= mem_wdata;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            mem_resp  <= 1'b1;
            mem_rdata <= hit_word;
            state     <= IDLE;
          end else begin
            victim_p0 <= victim;
            if (victim_dirty) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag_q[idx][victim], idx, {s_offset{1'b0}}};
              state        <= WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, idx, {s_offset{1'b0}}};
              state        <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, idx, {s_offset{1'b0}}};
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            state     <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid / dirty / PLRU state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (fill_en) begin
        valid_q[idx][victim_p0] <= 1'b1;
        dirty_q[idx][victim_p0] <= 1'b0;
      end
      if (hit_en) begin
        plru_q[idx] <= plru_next;
        if (req_write_p0) dirty_q[idx][hit_way] <= 1'b1;
      end
    end
  end

  // Tag and line storage (no reset; qualified by valid)
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx][victim_p0]  <= req_tag;
      line_q[idx][victim_p0] <= pmem_rdata;
    end else if (hit_en && req_write_p0) begin
      line_q[idx][hit_way] <= merged_line;
    end
  end

`ifdef CACHE_PERF_COUNTERS_EN
  // A CHECK directly after ALLOCATE is the post-fill lookup of a miss
  // already counted, so it does not count as a hit.
  logic from_alloc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      from_alloc <= 1'b0;
    end else begin
      if (fill_en) from_alloc <= 1'b1;
      else if (state == CHECK) from_alloc <= 1'b0;
      if (hit_en && !from_alloc && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if ((state == CHECK) && !hit && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway_wb.sv
// Testbench for cache_nway_wb (num_ways=4, s_index=3, s_offset=5).
// A backing-memory model answers pmem requests and logs each transfer;
// a scoreboard queue holds expected CPU responses, popped when mem_resp fires.
module tb_cache_nway_wb;

  localparam int MEM_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  always #5 clk = ~clk;

  cache_nway_wb dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
`ifdef CACHE_PERF_COUNTERS_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
`endif
    .pmem_resp       (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] w0;
  } pm_t;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  pm_t         pm_log[$];
  exp_t        exp_q[$];
  logic [31:0] ref_words [int unsigned];

  logic [255:0] bmem   [64];
  bit           bmem_v [64];
  int           mem_cnt;
  bit           mem_busy;
  pm_t          mem_ent;
  exp_t         mon_e;

  function automatic logic [31:0] pat_word(input logic [31:0] wa);
    if (wa == 32'h0000_0104) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ wa;
  endfunction

  function automatic logic [255:0] bm_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem_v[la[10:5]]) return bmem[la[10:5]];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = pat_word({la[31:5], 5'b0} + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (ref_words.exists(wa)) return ref_words[wa];
    l = bm_line({a[31:5], 5'b0});
    return l[32 * a[4:2] +: 32];
  endfunction

  // Backing memory: fixed latency, one-cycle pmem_resp, logs each transfer
  always @(posedge clk) begin
    if (rst) begin
      pmem_resp <= 1'b0;
      mem_cnt   <= 0;
      mem_busy  <= 1'b0;
    end else if (pmem_resp) begin
      pmem_resp <= 1'b0;
      mem_busy  <= 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (!mem_busy) begin
        mem_ent.wr   = pmem_write;
        mem_ent.addr = pmem_address;
        mem_ent.w0   = pmem_wdata[31:0];
        pm_log.push_back(mem_ent);
        mem_busy <= 1'b1;
      end
      if (mem_cnt == MEM_LAT - 1) begin
        mem_cnt   <= 0;
        pmem_resp <= 1'b1;
        if (pmem_write) begin
          bmem[pmem_address[10:5]]   <= pmem_wdata;
          bmem_v[pmem_address[10:5]] <= 1'b1;
        end else begin
          pmem_rdata <= bm_line(pmem_address);
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // Scoreboard: compare each response against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && mem_resp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_resp rdata=%h required no response", mem_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd) begin
          checks++;
          if (mem_rdata !== mon_e.data) begin
            errors++;
            $display("FAIL sb_rdata addr=%h got=%h want=%h", mon_e.addr, mem_rdata, mon_e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_words.delete();
    exp_q.delete();
    pm_log.delete();
  endtask

  // One CPU transaction; latency = clock edges from drive to mem_resp seen
  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, output int lat, output logic [31:0] rd);
    exp_t        e;
    logic [31:0] w;
    bit          got;
    int          n;
    @(negedge clk);
    mem_address     = addr;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = data;
    e.rd   = !wr;
    e.addr = addr;
    e.data = ref_word(addr);
    exp_q.push_back(e);
    if (wr) begin
      w = ref_word(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
      ref_words[{addr[31:2], 2'b00}] = w;
    end
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_resp) got = 1'b1;
    end
    rd        = mem_rdata;
    lat       = n;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout addr=%h got no mem_resp want one within 200 cycles", addr);
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got=%b want=0", mem_resp); end
    checks++;
    if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b want=0", pmem_read); end
    checks++;
    if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b want=0", pmem_write); end
    checks++;
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got=%h want=0", mem_rdata); end
    checks++;
    if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address got=%h want=0", pmem_address); end
  endtask

  task automatic test_cold_read();
    int lat; logic [31:0] rd; int n0;
    do_reset();
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h104, 4'h0, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_read_data got=%h want=deadbeef", rd); end
    checks++;
    if (pm_log.size() != n0 + 1) begin
      errors++; $display("FAIL cold_read_pmem_count got=%0d want=%0d", pm_log.size() - n0, 1);
    end else begin
      checks++;
      if (pm_log[n0].wr !== 1'b0 || pm_log[n0].addr !== 32'h100) begin
        errors++; $display("FAIL cold_read_fill got wr=%b addr=%h want wr=0 addr=00000100", pm_log[n0].wr, pm_log[n0].addr);
      end
    end
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h104, 4'h0, 32'h0, lat, rd);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL repeat_read_latency got=%0d want=2", lat); end
    checks++;
    if (pm_log.size() != n0) begin errors++; $display("FAIL repeat_read_pmem got=%0d want=0", pm_log.size() - n0); end
`ifdef CACHE_PERF_COUNTERS_EN
    checks++;
    if (miss_count !== 32'd1) begin errors++; $display("FAIL perf_miss_count got=%0d want=1", miss_count); end
    checks++;
    if (hit_count !== 32'd1) begin errors++; $display("FAIL perf_hit_count got=%0d want=1", hit_count); end
`endif
  endtask

  task automatic test_write_hit();
    int lat; logic [31:0] rd; int n0;
    n0 = pm_log.size();
    cpu_access(1'b1, 32'h104, 4'b0011, 32'h1234_5678, lat, rd);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL write_hit_latency got=%0d want=2", lat); end
    cpu_access(1'b0, 32'h104, 4'h0, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'hDEAD_5678) begin errors++; $display("FAIL write_merge_data got=%h want=dead5678", rd); end
    checks++;
    if (pm_log.size() != n0) begin errors++; $display("FAIL write_hit_pmem got=%0d want=0", pm_log.size() - n0); end
  endtask

  task automatic test_plru();
    int lat; logic [31:0] rd; int n0;
    logic [31:0] seq [5];
    seq = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000};
    do_reset();
    for (int i = 0; i < 5; i++) cpu_access(1'b0, seq[i], 4'h0, 32'h0, lat, rd);
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h400, 4'h0, 32'h0, lat, rd);
    checks++;
    if (pm_log.size() != n0 + 1) begin
      errors++; $display("FAIL plru_evict_count got=%0d want=1", pm_log.size() - n0);
    end else begin
      checks++;
      if (pm_log[n0].wr !== 1'b0 || pm_log[n0].addr !== 32'h400) begin
        errors++; $display("FAIL plru_evict_fill got wr=%b addr=%h want wr=0 addr=00000400", pm_log[n0].wr, pm_log[n0].addr);
      end
    end
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h000, 4'h0, 32'h0, lat, rd);
    checks++;
    if (lat != 2 || pm_log.size() != n0) begin
      errors++; $display("FAIL plru_keep_0 got lat=%0d pmem=%0d want lat=2 pmem=0", lat, pm_log.size() - n0);
    end
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h200, 4'h0, 32'h0, lat, rd);
    checks++;
    if (pm_log.size() != n0 + 1 || pm_log[pm_log.size()-1].addr !== 32'h200) begin
      errors++; $display("FAIL plru_victim_200 got pmem=%0d want 1 fill at 00000200", pm_log.size() - n0);
    end
  endtask

  task automatic test_dirty_evict();
    int lat; logic [31:0] rd; int n0;
    logic [31:0] seq [3];
    seq = '{32'h000, 32'h200, 32'h300};
    do_reset();
    cpu_access(1'b1, 32'h100, 4'b1111, 32'hAABB_CCDD, lat, rd);
    for (int i = 0; i < 3; i++) cpu_access(1'b0, seq[i], 4'h0, 32'h0, lat, rd);
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h400, 4'h0, 32'h0, lat, rd);
    checks++;
    if (pm_log.size() != n0 + 2) begin
      errors++; $display("FAIL dirty_evict_count got=%0d want=2", pm_log.size() - n0);
    end else begin
      checks++;
      if (pm_log[n0].wr !== 1'b1 || pm_log[n0].addr !== 32'h100 || pm_log[n0].w0 !== 32'hAABB_CCDD) begin
        errors++; $display("FAIL dirty_writeback got wr=%b addr=%h w0=%h want wr=1 addr=00000100 w0=aabbccdd",
                           pm_log[n0].wr, pm_log[n0].addr, pm_log[n0].w0);
      end
      checks++;
      if (pm_log[n0+1].wr !== 1'b0 || pm_log[n0+1].addr !== 32'h400) begin
        errors++; $display("FAIL dirty_refill got wr=%b addr=%h want wr=0 addr=00000400", pm_log[n0+1].wr, pm_log[n0+1].addr);
      end
    end
    // Read back the evicted word through a fresh fill from memory
    cpu_access(1'b0, 32'h100, 4'h0, 32'h0, lat, rd);
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; int n0; int n;
    do_reset();
    @(negedge clk);
    mem_address = 32'h600;
    mem_read    = 1'b1;
    n = 0;
    while (pmem_read !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (pmem_read !== 1'b1) begin errors++; $display("FAIL abort_fill_start got pmem_read=%b want 1", pmem_read); end
    @(negedge clk);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin errors++; $display("FAIL abort_pmem_read got=%b want=0", pmem_read); end
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL abort_mem_resp got=%b want=0", mem_resp); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ref_words.delete();
    n0 = pm_log.size();
    cpu_access(1'b0, 32'h600, 4'h0, 32'h0, lat, rd);
    checks++;
    if (pm_log.size() != n0 + 1 || pm_log[pm_log.size()-1].addr !== 32'h600) begin
      errors++; $display("FAIL abort_reread_miss got pmem=%0d want 1 fill at 00000600", pm_log.size() - n0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_plru();
    test_dirty_evict();
    test_reset_abort();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
